// File: rtl/branch_resolve_unit_if.sv
// Branch resolve bus: decoded branch in, outcome/redirect/flush/stats out.
// master = upstream decode + fetch side, slave = branch_resolve_unit.
interface branch_resolve_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  rs1_data;
  logic [XLEN-1:0]  rs2_data;
  logic [12:0]      imm;
  logic [2:0]       branch_control;

  logic             resolved_valid;
  logic             resolved_taken;
  logic [XLEN-1:0]  resolved_target;

  logic             redirect_valid;
  logic             redirect_ready;
  logic [XLEN-1:0]  redirect_pc;

  logic             flush;
  logic             misaligned;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] taken_count;

  modport master (
    output in_valid, pc, rs1_data, rs2_data, imm, branch_control, redirect_ready,
    input  in_ready, resolved_valid, resolved_taken, resolved_target,
           redirect_valid, redirect_pc, flush, misaligned, branch_count, taken_count
  );

  modport slave (
    input  in_valid, pc, rs1_data, rs2_data, imm, branch_control, redirect_ready,
    output in_ready, resolved_valid, resolved_taken, resolved_target,
           redirect_valid, redirect_pc, flush, misaligned, branch_count, taken_count
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Execute-stage conditional branch resolution with static not-taken prediction:
// taken, aligned branches raise a held fetch redirect followed by a fixed flush.
module branch_resolve_unit #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  branch_resolve_unit_if.slave bus
);

  localparam logic [2:0] BEQ    = 3'b000;
  localparam logic [2:0] BNE    = 3'b001;
  localparam logic [2:0] BR_NOP = 3'b010;
  localparam logic [2:0] BLT    = 3'b100;
  localparam logic [2:0] BGE    = 3'b101;
  localparam logic [2:0] BLTU   = 3'b110;
  localparam logic [2:0] BGEU   = 3'b111;

  localparam int FW = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES);

  typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH} state_t;

  state_t          state;
  logic [FW-1:0]   flush_cnt;
  logic            taken;
  logic [XLEN-1:0] target;
  logic            accept;

  // Condition and target are evaluated straight off the inputs so the
  // accept edge can register the outcome directly.
  always_comb begin
    taken = 1'b0;
    case (bus.branch_control)
      BEQ:     taken = (bus.rs1_data == bus.rs2_data);
      BNE:     taken = (bus.rs1_data != bus.rs2_data);
      BLT:     taken = ($signed(bus.rs1_data) <  $signed(bus.rs2_data));
      BGE:     taken = ($signed(bus.rs1_data) >= $signed(bus.rs2_data));
      BLTU:    taken = (bus.rs1_data <  bus.rs2_data);
      BGEU:    taken = (bus.rs1_data >= bus.rs2_data);
      default: taken = 1'b0;
    endcase
  end

  assign target      = bus.pc + {{(XLEN-13){bus.imm[12]}}, bus.imm};
  assign accept      = bus.in_valid && bus.in_ready;
  assign bus.in_ready = rst_n && (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      flush_cnt           <= '0;
      bus.resolved_valid  <= 1'b0;
      bus.resolved_taken  <= 1'b0;
      bus.resolved_target <= '0;
      bus.redirect_valid  <= 1'b0;
      bus.redirect_pc     <= '0;
      bus.flush           <= 1'b0;
      bus.misaligned      <= 1'b0;
      bus.branch_count    <= '0;
      bus.taken_count     <= '0;
    end else begin
      bus.resolved_valid <= 1'b0;
      bus.misaligned     <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            bus.resolved_valid  <= 1'b1;
            bus.resolved_taken  <= taken;
            bus.resolved_target <= target;
            if (bus.branch_control != BR_NOP)
              bus.branch_count <= bus.branch_count + CNT_W'(1);
            if (taken) begin
              bus.taken_count <= bus.taken_count + CNT_W'(1);
              // A misaligned target is reported but never fetched from.
              if (target[1]) begin
                bus.misaligned <= 1'b1;
              end else begin
                bus.redirect_valid <= 1'b1;
                bus.redirect_pc    <= target;
                state              <= REDIRECT;
              end
            end
          end
        end
        REDIRECT: begin
          if (bus.redirect_ready) begin
            bus.redirect_valid <= 1'b0;
            if (FLUSH_CYCLES > 0) begin
              bus.flush <= 1'b1;
              flush_cnt <= FW'(FLUSH_CYCLES - 1);
              state     <= FLUSH;
            end else begin
              state <= IDLE;
            end
          end
        end
        FLUSH: begin
          if (flush_cnt == '0) begin
            bus.flush <= 1'b0;
            state     <= IDLE;
          end else begin
            flush_cnt <= flush_cnt - FW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: condition codes, redirect hold,
// flush length, misalignment, target wrap, counters and mid-flush reset.
module tb_branch_resolve_unit;

  localparam logic [2:0] BEQ    = 3'b000;
  localparam logic [2:0] BNE    = 3'b001;
  localparam logic [2:0] BR_NOP = 3'b010;
  localparam logic [2:0] BLT    = 3'b100;
  localparam logic [2:0] BGE    = 3'b101;
  localparam logic [2:0] BLTU   = 3'b110;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  branch_resolve_unit_if #(.XLEN(32), .CNT_W(32)) bus ();

  branch_resolve_unit #(.XLEN(32), .FLUSH_CYCLES(2), .CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Drive one branch at a negedge and hold in_valid for 'beats' rising edges.
  task automatic applyStimulus(input logic [2:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] p, input logic [12:0] im, input int beats);
    @(negedge clk);
    bus.branch_control = ctrl;
    bus.rs1_data       = a;
    bus.rs2_data       = b;
    bus.pc             = p;
    bus.imm            = im;
    bus.in_valid       = 1'b1;
    repeat (beats) @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.in_ready) break;
    end
    checkOutput(tag, 64'(bus.in_ready), 64'd1);
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    checks             = 0;
    errors             = 0;
    rst_n              = 1'b0;
    bus.in_valid       = 1'b0;
    bus.pc             = '0;
    bus.rs1_data       = '0;
    bus.rs2_data       = '0;
    bus.imm            = '0;
    bus.branch_control = BR_NOP;
    bus.redirect_ready = 1'b1;

    repeat (2) @(negedge clk);
    checkOutput("rst_redirect_valid", 64'(bus.redirect_valid), 64'd0);
    checkOutput("rst_flush", 64'(bus.flush), 64'd0);
    checkOutput("rst_branch_count", 64'(bus.branch_count), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // BEQ taken, immediate redirect acceptance, two flush cycles.
    applyStimulus(BEQ, 32'h5, 32'h5, 32'h100, 13'h010, 1);
    @(negedge clk);
    checkOutput("beq_resolved_valid", 64'(bus.resolved_valid), 64'd1);
    checkOutput("beq_taken", 64'(bus.resolved_taken), 64'd1);
    checkOutput("beq_target", 64'(bus.resolved_target), 64'h110);
    checkOutput("beq_redirect_valid", 64'(bus.redirect_valid), 64'd1);
    checkOutput("beq_redirect_pc", 64'(bus.redirect_pc), 64'h110);
    checkOutput("beq_in_ready_k1", 64'(bus.in_ready), 64'd0);
    checkOutput("beq_taken_count", 64'(bus.taken_count), 64'd1);
    checkOutput("beq_branch_count", 64'(bus.branch_count), 64'd1);
    @(negedge clk);
    checkOutput("beq_rv_drop", 64'(bus.redirect_valid), 64'd0);
    checkOutput("beq_resolved_pulse", 64'(bus.resolved_valid), 64'd0);
    checkOutput("beq_flush_1", 64'(bus.flush), 64'd1);
    checkOutput("beq_in_ready_k2", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    checkOutput("beq_flush_2", 64'(bus.flush), 64'd1);
    checkOutput("beq_in_ready_k3", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    checkOutput("beq_flush_end", 64'(bus.flush), 64'd0);
    checkOutput("beq_in_ready_k4", 64'(bus.in_ready), 64'd1);

    // BLT signed: -1 < 1 is taken.
    applyStimulus(BLT, 32'hFFFF_FFFF, 32'h1, 32'h300, 13'h008, 1);
    @(negedge clk);
    checkOutput("blt_taken", 64'(bus.resolved_taken), 64'd1);
    checkOutput("blt_redirect_pc", 64'(bus.redirect_pc), 64'h308);
    waitIdle("blt_idle");
    checkOutput("blt_taken_count", 64'(bus.taken_count), 64'd2);

    // BLTU unsigned: 0xFFFFFFFF < 1 is false; two back-to-back accepts.
    applyStimulus(BLTU, 32'hFFFF_FFFF, 32'h1, 32'h300, 13'h008, 2);
    @(negedge clk);
    checkOutput("bltu_resolved_valid", 64'(bus.resolved_valid), 64'd1);
    checkOutput("bltu_taken", 64'(bus.resolved_taken), 64'd0);
    checkOutput("bltu_redirect_valid", 64'(bus.redirect_valid), 64'd0);
    checkOutput("bltu_in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("bltu_branch_count", 64'(bus.branch_count), 64'd4);
    checkOutput("bltu_taken_count", 64'(bus.taken_count), 64'd2);

    // BNE taken backward branch with fetch stalling the redirect.
    bus.redirect_ready = 1'b0;
    applyStimulus(BNE, 32'h1, 32'h2, 32'h200, 13'h1FFC, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bne_hold_valid", 64'(bus.redirect_valid), 64'd1);
      checkOutput("bne_hold_pc", 64'(bus.redirect_pc), 64'h1FC);
      checkOutput("bne_hold_in_ready", 64'(bus.in_ready), 64'd0);
    end
    applyStimulus(BEQ, 32'h7, 32'h7, 32'h400, 13'h010, 1);
    @(negedge clk);
    checkOutput("bne_ignored_branch_count", 64'(bus.branch_count), 64'd5);
    checkOutput("bne_ignored_taken_count", 64'(bus.taken_count), 64'd3);
    checkOutput("bne_still_pc", 64'(bus.redirect_pc), 64'h1FC);
    bus.redirect_ready = 1'b1;
    @(negedge clk);
    checkOutput("bne_rv_drop", 64'(bus.redirect_valid), 64'd0);
    checkOutput("bne_flush", 64'(bus.flush), 64'd1);
    waitIdle("bne_idle");

    // Misaligned taken target, counted from a fresh reset.
    resetDut();
    applyStimulus(BGE, 32'h3, 32'h3, 32'h102, 13'h000, 1);
    @(negedge clk);
    checkOutput("mis_pulse", 64'(bus.misaligned), 64'd1);
    checkOutput("mis_taken", 64'(bus.resolved_taken), 64'd1);
    checkOutput("mis_redirect_valid", 64'(bus.redirect_valid), 64'd0);
    checkOutput("mis_in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("mis_branch_count", 64'(bus.branch_count), 64'd1);
    checkOutput("mis_taken_count", 64'(bus.taken_count), 64'd1);
    @(negedge clk);
    checkOutput("mis_pulse_end", 64'(bus.misaligned), 64'd0);
    checkOutput("mis_no_flush", 64'(bus.flush), 64'd0);

    // Target wraps modulo 2^32.
    applyStimulus(BEQ, 32'h0, 32'h0, 32'hFFFF_FFF0, 13'h020, 1);
    @(negedge clk);
    checkOutput("wrap_redirect_pc", 64'(bus.redirect_pc), 64'h10);
    checkOutput("wrap_redirect_valid", 64'(bus.redirect_valid), 64'd1);
    waitIdle("wrap_idle");

    // BR_NOP resolves not-taken and is not counted.
    applyStimulus(BR_NOP, 32'h9, 32'h9, 32'h500, 13'h010, 1);
    @(negedge clk);
    checkOutput("nop_resolved_valid", 64'(bus.resolved_valid), 64'd1);
    checkOutput("nop_taken", 64'(bus.resolved_taken), 64'd0);
    checkOutput("nop_branch_count", 64'(bus.branch_count), 64'd2);
    checkOutput("nop_taken_count", 64'(bus.taken_count), 64'd2);

    // Asynchronous reset in the middle of a flush.
    applyStimulus(BEQ, 32'h1, 32'h1, 32'h600, 13'h040, 1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("rstf_flush_before", 64'(bus.flush), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rstf_flush", 64'(bus.flush), 64'd0);
    checkOutput("rstf_redirect_valid", 64'(bus.redirect_valid), 64'd0);
    checkOutput("rstf_redirect_pc", 64'(bus.redirect_pc), 64'd0);
    checkOutput("rstf_target", 64'(bus.resolved_target), 64'd0);
    checkOutput("rstf_taken", 64'(bus.resolved_taken), 64'd0);
    checkOutput("rstf_branch_count", 64'(bus.branch_count), 64'd0);
    checkOutput("rstf_taken_count", 64'(bus.taken_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rstf_in_ready", 64'(bus.in_ready), 64'd1);
    applyStimulus(BLTU, 32'h1, 32'h2, 32'h40, 13'h040, 1);
    @(negedge clk);
    checkOutput("post_taken", 64'(bus.resolved_taken), 64'd1);
    checkOutput("post_target", 64'(bus.resolved_target), 64'h80);
    checkOutput("post_branch_count", 64'(bus.branch_count), 64'd1);
    checkOutput("post_taken_count", 64'(bus.taken_count), 64'd1);
    waitIdle("post_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Execute-stage branch resolution block that sits directly downstream of branch decode. It accepts one decoded conditional branch per handshake: rs1/rs2 operand values, 13-bit B-type immediate, 3-bit branch control code and branch PC. It evaluates the condition, computes the target and drives a held fetch redirect, followed by a fixed-length pipeline flush. The design uses static not-taken prediction, so only taken branches redirect; it also keeps taken/total branch counters.

## Interface
- XLEN, 32, operand/PC width
- FLUSH_CYCLES, 2, cycles `flush` stays high after a redirect is accepted; 0 skips the flush
- CNT_W, 32, statistics counter width
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  decoded branch present
- in_ready  output  1  block can accept a branch
- pc  input  XLEN  branch instruction address
- rs1_data, rs2_data  input  XLEN  operand values
- imm  input  13  B-type immediate, bit 0 always 0
- branch_control  input  3  `BEQ/`BNE/`BLT/`BGE/`BLTU/`BGEU/`BR_NOP from processor_defines.sv
- resolved_valid  output  1  one-cycle pulse: outcome fields valid
- resolved_taken  output  1  condition result
- resolved_target  output  XLEN  pc + sign-extended imm
- redirect_valid  output  1  fetch redirect request
- redirect_ready  input  1  fetch accepts redirect
- redirect_pc  output  XLEN  redirect address
- flush  output  1  kill younger in-flight instructions
- misaligned  output  1  one-cycle pulse: taken target not 4-byte aligned
- branch_count, taken_count  output  CNT_W  statistics

## Operation
- States: IDLE, REDIRECT, FLUSH. `in_ready` = (state == IDLE).
- A branch is accepted on an edge where in_valid && in_ready. Operands, imm, pc and control are registered then.
- Condition evaluation:
  - BEQ/BNE use equality.
  - BLT/BGE use signed compare.
  - BLTU/BGEU use unsigned compare.
  - BR_NOP and any other code give taken=0.
- Target: pc + {{(XLEN-13){imm[12]}}, imm}, computed modulo 2^XLEN (wraps, no overflow flag).
- branch_count increments on every accept except BR_NOP. taken_count increments when taken=1. Both wrap at 2^CNT_W.
- After accept, the state transition is:
  - not taken: stays IDLE.
  - taken and target[1] == 1: `misaligned` pulses, no redirect, no flush, stays IDLE. Counters still count it as taken.
  - taken and aligned: go to REDIRECT.
- REDIRECT:
  - redirect_valid = 1 and redirect_pc = registered target, held stable until redirect_ready is sampled high.
  - Accepting edge: go to FLUSH when FLUSH_CYCLES > 0, else IDLE.
- FLUSH: flush = 1 for exactly FLUSH_CYCLES cycles (down-counter), then IDLE.
- Reset, including mid-REDIRECT/FLUSH, forces the following immediately and asynchronously:
  - state IDLE
  - in_ready 1 (only once reset is released)
  - resolved_valid, resolved_taken, redirect_valid, flush, misaligned 0
  - resolved_target, redirect_pc 0
  - counters 0
- No pending redirect survives reset.

## Timing
- Accept at edge k. resolved_* and misaligned are valid during cycle k+1 only.
- Taken, aligned: redirect_valid rises in cycle k+1, together with resolved_valid.
- Redirect accepted at edge r: redirect_valid low from cycle r+1. flush is high in cycles r+1 .. r+FLUSH_CYCLES. in_ready is high again in cycle r+FLUSH_CYCLES+1.
- redirect_ready high in cycle k+1 gives r = k+1 (minimum 1-cycle redirect).
- Not-taken or misaligned branch: in_ready stays high, so back-to-back accepts at every edge are allowed (throughput 1/cycle).
- redirect_ready is ignored outside REDIRECT. in_valid is ignored while in_ready = 0.
- Counters update at the accept edge and are visible in cycle k+1.

## Test plan
- BEQ, rs1=rs2=0x5, pc=0x100, imm=0x010, redirect_ready held 1:
  - resolved_taken=1, target=0x110 at k+1.
  - redirect_valid one cycle, then flush 2 cycles.
  - in_ready back at k+4.
  - taken_count=1.
- BLT rs1=0xFFFFFFFF, rs2=1 → taken. BLTU with the same operands → not taken, no redirect, in_ready never drops.
- BNE taken, pc=0x200, imm=0x1FFC (−4): redirect_pc=0x1FC.
  - redirect_ready low for 5 cycles: redirect_valid and redirect_pc held stable, in_ready=0.
  - Later in_valid pulses are ignored.
- Taken BGE with pc=0x102, imm=0: misaligned pulses, no redirect/flush, counters 1/1.
- Target wrap: pc=0xFFFFFFF0, imm=0x020 → redirect_pc=0x00000010. BR_NOP accept → taken=0, branch_count unchanged.
- rst_n asserted during the FLUSH cycle → all outputs and counters 0 immediately. After release: in_ready=1 and the next branch resolves normally.
